// File: rtl/dmem_mmio_responder_if.sv
// Data-memory bus between the PMIPS MEM stage and its responder.
// Combinational read path: dmemrdata follows dmemaddr/dmemread in the same cycle.
interface dmem_mmio_responder_if;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;

    modport master (
        output dmemaddr,
        output dmemwdata,
        output dmemwrite,
        output dmemread,
        input  dmemrdata
    );

    modport slave (
        input  dmemaddr,
        input  dmemwdata,
        input  dmemwrite,
        input  dmemread,
        output dmemrdata
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Word RAM plus MMIO page (LEDs, switches, status) for the PMIPS data bus.
// Define DMEM_MMIO_TIMER_EN to build the prescaled timer and its TCTRL register.
module dmem_mmio_responder #(
    parameter int RAM_AW   = 7,
    parameter int PRESCALE = 50,
    parameter int SW_W     = 4
) (
    input  logic                clock,
    input  logic                reset,
    dmem_mmio_responder_if.slave bus,
    input  logic [SW_W-1:0]     sw,
    output logic [7:0]          leds,
    output logic                err
);

    localparam logic [14:0] WC_MAX = 15'h7FFF;

    logic              is_mmio;
    logic [RAM_AW-1:0] idx;
    logic [2:0]        reg_off;
    logic              wr;
    logic              access;
    logic              sel_led;
    logic              sel_sw;
    logic              sel_stat;
    logic              sel_unmap;
    logic [14:0]       wr_count;
    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;
    logic [15:0]       sw_word;
    logic [15:0]       rdata;
    logic              unused_addr;

    logic [15:0] ram [2**RAM_AW];

    assign is_mmio  = bus.dmemaddr[15];
    assign idx      = bus.dmemaddr[RAM_AW:1];
    assign reg_off  = bus.dmemaddr[3:1];
    assign wr       = bus.dmemwrite;
    assign access   = bus.dmemwrite | bus.dmemread;
    assign sel_led  = is_mmio && (reg_off == 3'd0);
    assign sel_sw   = is_mmio && (reg_off == 3'd1);
    assign sel_stat = is_mmio && (reg_off == 3'd4);
    assign sw_word  = 16'(sw_sync);

    // Only the decoded bits matter; the rest of the address aliases.
    assign unused_addr = ^bus.dmemaddr;

`ifdef DMEM_MMIO_TIMER_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic            sel_tmr;
    logic            sel_tctl;
    logic            tctl_wr;
    logic [15:0]     timer;
    logic            timer_en;
    logic [PS_W-1:0] pcnt;

    assign sel_tmr   = is_mmio && (reg_off == 3'd2);
    assign sel_tctl  = is_mmio && (reg_off == 3'd3);
    assign tctl_wr   = wr && sel_tctl;
    assign sel_unmap = is_mmio &&
                       !(sel_led | sel_sw | sel_stat | sel_tmr | sel_tctl);

    // Clear beats any tick landing on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer    <= '0;
            timer_en <= 1'b0;
            pcnt     <= '0;
        end else begin
            if (tctl_wr) begin
                timer_en <= bus.dmemwdata[0];
            end
            if (tctl_wr && bus.dmemwdata[1]) begin
                timer <= '0;
                pcnt  <= '0;
            end else if (timer_en) begin
                if (pcnt == PS_LAST) begin
                    pcnt  <= '0;
                    timer <= timer + 16'd1;
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
            end
        end
    end
`else
    assign sel_unmap = is_mmio && !(sel_led | sel_sw | sel_stat);
`endif

    // A write on an edge where reset is held low is dropped.
    always_ff @(posedge clock) begin
        if (reset && wr && !is_mmio) begin
            ram[idx] <= bus.dmemwdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leds     <= 8'h00;
            err      <= 1'b0;
            wr_count <= '0;
        end else begin
            if (wr && sel_led) begin
                leds <= bus.dmemwdata[7:0];
            end
            if (wr && sel_stat) begin
                err      <= 1'b0;
                wr_count <= '0;
            end else begin
                if (access && sel_unmap) begin
                    err <= 1'b1;
                end
                if (wr && !sel_unmap && wr_count != WC_MAX) begin
                    wr_count <= wr_count + 15'd1;
                end
            end
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (bus.dmemread) begin
            unique case (1'b1)
                !is_mmio: rdata = ram[idx];
                sel_led:  rdata = {8'h00, leds};
                sel_sw:   rdata = sw_word;
`ifdef DMEM_MMIO_TIMER_EN
                sel_tmr:  rdata = timer;
                sel_tctl: rdata = {15'h0000, timer_en};
`endif
                sel_stat: rdata = {err, wr_count};
                default:  rdata = 16'h0000;
            endcase
        end
    end

    assign bus.dmemrdata = rdata;

endmodule
